// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker.
//   state_t            : sequencer states
//   SYSID_ADDR_*       : word addresses inside the sysid slave
//   DEF_EXPECTED_*     : default build-time values compared against
package sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID        = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'h5988_FBE8;
endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker and the sysid slave.
//   master : avm_address/avm_read out, avm_waitrequest/avm_readdata in
//   slave  : mirror image
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read,
                  input  avm_waitrequest, avm_readdata);
  modport slave  (input  avm_address, avm_read,
                  output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_read_port.sv
// Single-access Avalon read engine.
//   req/addr : one-cycle request; strobe is raised on the next edge
//   accept   : read accepted this cycle (strobe high, waitrequest low)
//   ack      : read data valid this cycle (rdata)
//   timeout  : last tolerated stall cycle; strobe drops on the next edge
//   avm      : Avalon master side
module sysid_read_port #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req,
  input  logic                        addr,
  sysid_boot_checker_if.master        avm,
  output logic                        accept,
  output logic                        ack,
  output logic                        timeout,
  output logic [31:0]                 rdata
);
  logic        rd;
  logic        rd_addr;
  logic [15:0] stall;
  logic        lat_act;
  logic [2:0]  lat_cnt;

  assign avm.avm_read    = rd;
  assign avm.avm_address = rd_addr;
  assign rdata           = avm.avm_readdata;

  assign accept  = rd && !avm.avm_waitrequest;
  // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout = rd && avm.avm_waitrequest && (stall == 16'(TIMEOUT_CYCLES - 1));
  // With zero latency the data rides alongside the accept.
  assign ack     = (READ_LATENCY == 0) ? accept
                                       : (lat_act && (lat_cnt == 3'(READ_LATENCY)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd      <= 1'b0;
      rd_addr <= 1'b0;
      stall   <= '0;
      lat_act <= 1'b0;
      lat_cnt <= '0;
    end else begin
      if (req) begin
        rd      <= 1'b1;
        rd_addr <= addr;
        stall   <= '0;
      end else if (rd) begin
        if (accept) begin
          rd      <= 1'b0;
          lat_act <= (READ_LATENCY != 0);
          lat_cnt <= 3'd1;
        end else if (timeout) begin
          rd <= 1'b0;
        end else begin
          stall <= stall + 16'd1;
        end
      end
      if (lat_act) begin
        if (ack) lat_act <= 1'b0;
        else     lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end
endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the sysid ID word then the timestamp
// word, compares both against build-time values and reports the verdict.
//   clock/reset_n : clock, async active-low reset
//   start         : one-cycle request, honoured only in IDLE
//   avm           : Avalon master to the sysid slave
//   busy/done     : sequence in flight / one-cycle end pulse
//   pass, err_*   : verdict levels, held until the next accepted start
//   id_q/ts_q     : captured words
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  sysid_boot_checker_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err_id,
  output logic                 err_ts,
  output logic                 err_timeout,
  output logic [31:0]          id_q,
  output logic [31:0]          ts_q
);
  state_t      state, state_nx;
  logic        req, req_addr, go, cap_id, cap_ts;
  logic        accept, ack, timeout;
  logic [31:0] rdata;
  logic        id_mis, ts_mis;

  sysid_read_port #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_port (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .addr   (req_addr),
    .avm    (avm),
    .accept (accept),
    .ack    (ack),
    .timeout(timeout),
    .rdata  (rdata)
  );

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // The timestamp request is issued in the same cycle the ID data lands,
  // so with a zero-wait slave the two reads run back to back.
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    req_addr = SYSID_ADDR_ID;
    go       = 1'b0;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        go = 1'b1; req = 1'b1; state_nx = RD_ID;
      end
      RD_ID, LAT_ID: begin
        if (timeout) state_nx = FIN;
        else if (ack) begin
          cap_id = 1'b1; req = 1'b1; req_addr = SYSID_ADDR_TS; state_nx = RD_TS;
        end else if (accept) state_nx = LAT_ID;
      end
      RD_TS, LAT_TS: begin
        if (timeout) state_nx = FIN;
        else if (ack) begin
          cap_ts = 1'b1; state_nx = FIN;
        end else if (accept) state_nx = LAT_TS;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Verdict is registered on the timestamp capture edge so it is already
  // valid during the FIN/done cycle; a timeout never reaches that edge.
  assign id_mis = (id_q != EXPECTED_ID);
  assign ts_mis = CHECK_TIMESTAMP && (rdata != EXPECTED_TIMESTAMP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass <= 1'b0; err_id <= 1'b0; err_ts <= 1'b0; err_timeout <= 1'b0;
      id_q <= '0;   ts_q <= '0;
    end else if (go) begin
      pass <= 1'b0; err_id <= 1'b0; err_ts <= 1'b0; err_timeout <= 1'b0;
      id_q <= '0;   ts_q <= '0;
    end else begin
      if (cap_id) id_q <= rdata;
      if (cap_ts) begin
        ts_q   <= rdata;
        err_id <= id_mis;
        err_ts <= ts_mis;
        pass   <= !(id_mis || ts_mis);
      end
      if (timeout) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: four checker instances (default, timestamp-ignore,
// latency 2, timeout 10) against simple sysid slave models.
module tb_sysid_boot_checker;
  logic clock = 1'b0;
  logic reset_n;
  logic start [4];
  logic busy [4], done [4], pass [4], err_id [4], err_ts [4], err_to [4];
  logic [31:0] id_q [4], ts_q [4];
  logic wr0, wr2;
  logic [31:0] slv_id, slv_ts;
  int vecs = 0;
  int miscmp = 0;

  always #5 clock = ~clock;

  sysid_boot_checker_if bus0 ();
  sysid_boot_checker_if bus1 ();
  sysid_boot_checker_if bus2 ();
  sysid_boot_checker_if bus3 ();

  // zero-latency slaves: data valid with the accepted strobe
  assign bus0.avm_waitrequest = wr0;
  assign bus0.avm_readdata = bus0.avm_read ? (bus0.avm_address ? slv_ts : slv_id) : 32'hDEADBEEF;
  assign bus1.avm_waitrequest = 1'b0;
  assign bus1.avm_readdata = bus1.avm_read ? (bus1.avm_address ? slv_ts : slv_id) : 32'hDEADBEEF;
  assign bus3.avm_waitrequest = 1'b1;
  assign bus3.avm_readdata = bus3.avm_read ? (bus3.avm_address ? slv_ts : slv_id) : 32'hDEADBEEF;

  // latency-2 slave: data valid only two cycles after the accept cycle
  logic p1_v, p1_a, p2_v, p2_a;
  assign bus2.avm_waitrequest = wr2;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_v <= 1'b0; p1_a <= 1'b0; p2_v <= 1'b0; p2_a <= 1'b0;
    end else begin
      p1_v <= bus2.avm_read && !bus2.avm_waitrequest;
      p1_a <= bus2.avm_address;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end
  assign bus2.avm_readdata = p2_v ? (p2_a ? slv_ts : slv_id) : 32'hDEADBEEF;

  sysid_boot_checker u0 (.clock(clock), .reset_n(reset_n), .start(start[0]), .avm(bus0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_id(err_id[0]), .err_ts(err_ts[0]),
    .err_timeout(err_to[0]), .id_q(id_q[0]), .ts_q(ts_q[0]));
  sysid_boot_checker #(.CHECK_TIMESTAMP(1'b0)) u1 (.clock(clock), .reset_n(reset_n),
    .start(start[1]), .avm(bus1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_id(err_id[1]), .err_ts(err_ts[1]), .err_timeout(err_to[1]), .id_q(id_q[1]), .ts_q(ts_q[1]));
  sysid_boot_checker #(.READ_LATENCY(2)) u2 (.clock(clock), .reset_n(reset_n),
    .start(start[2]), .avm(bus2), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_id(err_id[2]), .err_ts(err_ts[2]), .err_timeout(err_to[2]), .id_q(id_q[2]), .ts_q(ts_q[2]));
  sysid_boot_checker #(.TIMEOUT_CYCLES(10)) u3 (.clock(clock), .reset_n(reset_n),
    .start(start[3]), .avm(bus3), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .err_id(err_id[3]), .err_ts(err_ts[3]), .err_timeout(err_to[3]), .id_q(id_q[3]), .ts_q(ts_q[3]));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    wr0 = 1'b0; wr2 = 1'b0;
    slv_id = 32'h0000_0000; slv_ts = 32'h5988_FBE8;

    // reset state
    #12;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_read", bus3.avm_read, 0);
    chk("rst_addr", bus0.avm_address, 0);
    chk("rst_ts_q", ts_q[1], 0);
    @(posedge clock); #1 reset_n = 1'b1;
    tick();

    // A: clean zero-wait sequence, done three cycles after start
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("A_c1_read", bus0.avm_read, 1);
    chk("A_c1_addr", bus0.avm_address, 0);
    chk("A_c1_busy", busy[0], 1);
    tick();
    chk("A_c2_read", bus0.avm_read, 1);
    chk("A_c2_addr", bus0.avm_address, 1);
    tick();
    chk("A_c3_done", done[0], 1);
    chk("A_c3_busy", busy[0], 0);
    chk("A_c3_pass", pass[0], 1);
    chk("A_c3_id_q", id_q[0], 32'h0000_0000);
    chk("A_c3_ts_q", ts_q[0], 32'h5988_FBE8);
    chk("A_c3_read", bus0.avm_read, 0);
    tick();
    chk("A_c4_done", done[0], 0);
    chk("A_c4_pass", pass[0], 1);

    // B: wrong timestamp, checked (u0) and capture-only (u1)
    slv_ts = 32'h5988_FBE9;
    start[0] = 1'b1; start[1] = 1'b1; tick(); start[0] = 1'b0; start[1] = 1'b0;
    tick(); tick();
    chk("B_u0_done", done[0], 1);
    chk("B_u0_err_ts", err_ts[0], 1);
    chk("B_u0_pass", pass[0], 0);
    chk("B_u0_err_id", err_id[0], 0);
    chk("B_u1_done", done[1], 1);
    chk("B_u1_pass", pass[1], 1);
    chk("B_u1_err_ts", err_ts[1], 0);
    chk("B_u1_ts_q", ts_q[1], 32'h5988_FBE9);
    tick();

    // E: start while busy and on the done cycle ignored; next cycle accepted
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tick(); start[0] = 1'b1;
    tick();
    chk("E_c3_done", done[0], 1);
    chk("E_c3_err_ts", err_ts[0], 1);
    slv_ts = 32'h5988_FBE8;
    tick(); start[0] = 1'b0;
    chk("E_c4_busy", busy[0], 0);
    chk("E_c4_read", bus0.avm_read, 0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("E_c5_busy", busy[0], 1);
    chk("E_c5_err_ts", err_ts[0], 0);
    chk("E_c5_pass", pass[0], 0);
    tick(); tick();
    chk("E_c7_done", done[0], 1);
    chk("E_c7_pass", pass[0], 1);
    tick();

    // C: 3 stall cycles on the ID read, latency 2
    wr2 = 1'b1;
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    chk("C_c1_read", bus2.avm_read, 1);
    chk("C_c1_addr", bus2.avm_address, 0);
    tick(); chk("C_c2_read", bus2.avm_read, 1);
    tick(); chk("C_c3_read", bus2.avm_read, 1);
    tick(); wr2 = 1'b0;
    chk("C_c4_read", bus2.avm_read, 1);
    chk("C_c4_addr", bus2.avm_address, 0);
    tick();
    chk("C_c5_read", bus2.avm_read, 0);
    chk("C_c5_busy", busy[2], 1);
    tick(); tick();
    chk("C_c7_read", bus2.avm_read, 1);
    chk("C_c7_addr", bus2.avm_address, 1);
    chk("C_c7_id_q", id_q[2], 32'h0000_0000);
    tick(); tick();
    chk("C_c9_ts_q", ts_q[2], 32'h0000_0000);
    chk("C_c9_done", done[2], 0);
    tick();
    chk("C_c10_done", done[2], 1);
    chk("C_c10_pass", pass[2], 1);
    chk("C_c10_ts_q", ts_q[2], 32'h5988_FBE8);
    tick();

    // D: waitrequest stuck high, timeout after 10 stalled cycles
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("D_c%0d_read", i), bus3.avm_read, 1);
      tick();
    end
    chk("D_c11_read", bus3.avm_read, 0);
    chk("D_c11_done", done[3], 1);
    chk("D_c11_err_to", err_to[3], 1);
    chk("D_c11_pass", pass[3], 0);
    chk("D_c11_err_id", err_id[3], 0);
    chk("D_c11_err_ts", err_ts[3], 0);
    tick();
    chk("D_c12_read", bus3.avm_read, 0);
    chk("D_c12_addr", bus3.avm_address, 0);
    chk("D_c12_err_to", err_to[3], 1);
    tick();

    // F: reset asserted during LAT_TS, then a clean rerun
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    tick(); tick(); tick(); tick();
    chk("F_c5_busy", busy[2], 1);
    reset_n = 1'b0;
    #1;
    chk("F_rst_busy", busy[2], 0);
    chk("F_rst_read", bus2.avm_read, 0);
    chk("F_rst_u1_ts_q", ts_q[1], 0);
    chk("F_rst_u1_pass", pass[1], 0);
    chk("F_rst_u3_err_to", err_to[3], 0);
    @(posedge clock); #1 reset_n = 1'b1;
    tick();
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    begin
      int n;
      n = 0;
      while (!done[2] && n < 30) begin tick(); n++; end
    end
    chk("F_done", done[2], 1);
    chk("F_pass", pass[2], 1);
    chk("F_ts_q", ts_q[2], 32'h5988_FBE8);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
